ascon_permutation_iter: RTL and testbench
=========================================

Name: ascon_permutation_iter

Overview:
- Iterative, multi-cycle Ascon permutation engine (p6 / p8 / p12). It is the responder on the permutation interface that the encrypt/decrypt, init and finalization stages drive.
- Accepts a 320-bit state (x0..x4) on a start handshake and executes UNROLL rounds per clock. It returns the permuted state with a single-cycle done pulse.
- Replaces the fully unrolled combinational p8 so that rounds are time-shared and area is bounded.

Parameters:
UNROLL, 1, rounds per clock cycle; legal values 1, 2. Other values are a synthesis-time error.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only when busy=0
rounds_sel  in  2  0: p6, 1: p8, 2: p12, 3: illegal
x0_i  in  64  state word 0
x1_i  in  64  state word 1
x2_i  in  64  state word 2
x3_i  in  64  state word 3
x4_i  in  64  state word 4
x0_o  out  64  permuted state word 0 (registered)
x1_o  out  64  permuted state word 1 (registered)
x2_o  out  64  permuted state word 2 (registered)
x3_o  out  64  permuted state word 3 (registered)
x4_o  out  64  permuted state word 4 (registered)
busy  out  1  high while rounds are executing
done  out  1  one-cycle pulse; x*_o valid
err  out  1  one-cycle pulse; illegal rounds_sel on start

Behaviour:
- Reset: x0_o..x4_o=0, busy=0, done=0, err=0, round counter rc=0, FSM=IDLE. Reset mid-operation aborts immediately; no done is produced.
- FSM states: IDLE, RUN.
- IDLE and start=1 with rounds_sel in {0,1,2}:
  - load state regs from x*_i;
  - rc <= 12-N, where N = 6/8/12;
  - busy<=1, go to RUN.
- IDLE and start=1 with rounds_sel=3: err<=1 for one cycle, state regs untouched, stay IDLE.
- RUN, each cycle: apply UNROLL rounds to the state regs, rc += UNROLL.
  - When the new rc equals 12: busy<=0, done<=1 in the same edge, go to IDLE.
- Latency: with start sampled at edge k, done=1 and the final state are visible after edge k+N/UNROLL.
  - UNROLL=1: p6=6, p8=8, p12=12 cycles.
  - UNROLL=2: p6=3, p8=4, p12=6 cycles.
  - Throughput is one permutation per N/UNROLL+1 cycles.
- Round i (i = rc value for that round):
  - Constant addition: x2 ^= {56'b0, ((15-i)<<4) | i}.
  - S-box layer, bitsliced on 64-bit words:
    - x0^=x4; x4^=x3; x2^=x1;
    - t_j = ~x_j & x_(j+1 mod 5);
    - x_j ^= t_(j+1 mod 5);
    - x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer, rotates right:
    - x0^=ror19^ror28; x1^=ror61^ror39; x2^=ror1^ror6; x3^=ror10^ror17; x4^=ror7^ror41.
- Outputs: x*_o are the state regs themselves. They change during RUN (intermediate values, not valid) and hold the final value from done until the next accepted start.
- start while busy=1 is ignored (no queueing). The requester must wait for done.
- start in the same cycle done is high: the FSM is in IDLE, so start is accepted. done falls and busy rises on the next edge.
- rounds_sel and x*_i are sampled only on the accepting edge; later changes have no effect.
- done and err never assert in the same cycle.

Test Plan:
1. Ascon-128 init: state = IV 0x80400c0600000000, key = 0, nonce = 0; rounds_sel=2, UNROLL=1 -> done exactly 12 cycles after start, busy high for 12 cycles, x*_o bit-exact with the ascon-c p12 golden model.
2. rounds_sel=1 with random state; probe x2 low byte after round 1 -> first constant 0xb4 applied. Final state matches the golden p8; latency 8 (UNROLL=1) and 4 (UNROLL=2).
3. rounds_sel=0 -> first constant 0x96, 6-cycle latency. Pulse start again at cycles 2 and 4 while busy -> ignored; exactly one done.
4. rounds_sel=3 with start -> err=1 for one cycle, busy stays 0, x*_o unchanged, no done.
5. Back-to-back: start asserted in the done cycle with a new state -> accepted; second result correct and done spacing = N/UNROLL+1 cycles.
6. rst_n asserted low at cycle 5 of a p12 run -> all outputs 0 asynchronously. A new p8 start after release gives the correct result.

Source files
------------

// File: rtl/ascon_permutation_iter.sv
// Iterative Ascon permutation (p6/p8/p12): loads a 320-bit state on start, applies
// UNROLL rounds per clock and returns the result with a one-cycle done pulse.
module ascon_permutation_iter #(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  rounds_sel,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    output logic        busy,
    output logic        done,
    output logic        err
);

    generate
        if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
            $error("ascon_permutation_iter: UNROLL must be 1 or 2");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_e;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One Ascon round; i is the absolute round index 0..11 of a p12 schedule.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'b0, ~i, i};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    state_e       state_q, state_d;
    logic [319:0] st_q, st_d;
    logic [3:0]   rc_q, rc_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [319:0] round_s;
    logic [3:0]   rc_next;

    always_comb begin
        round_s = st_q;
        for (int u = 0; u < UNROLL; u++) begin
            round_s = ascon_round(round_s, rc_q + 4'(u));
        end
        rc_next = rc_q + 4'(UNROLL);
    end

    // Handshake: start is sampled only in IDLE (busy=0); the result is valid on
    // x*_o from the done pulse until the next accepted start. No queueing.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rc_d    = rc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (rounds_sel == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        st_d    = {x0_i, x1_i, x2_i, x3_i, x4_i};
                        rc_d    = (rounds_sel == 2'd0) ? 4'd6 :
                                  (rounds_sel == 2'd1) ? 4'd4 : 4'd0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                st_d = round_s;
                rc_d = rc_next;
                if (rc_next == 4'd12) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            rc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rc_q    <= rc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign {x0_o, x1_o, x2_o, x3_o, x4_o} = st_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Bench for ascon_permutation_iter: bit-level reference model built on the 5-bit
// S-box table, with a scoreboard of expected states and latencies.
module tb_ascon_permutation_iter;

    localparam int U = 1;

    logic        clk, rst_n, start;
    logic [1:0]  rounds_sel;
    logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
    logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
    logic        busy, done, err;
    logic [319:0] dut_state;

    ascon_permutation_iter #(.UNROLL(U)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rounds_sel(rounds_sel),
        .x0_i(x0_i), .x1_i(x1_i), .x2_i(x2_i), .x3_i(x3_i), .x4_i(x4_i),
        .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o), .x4_o(x4_o),
        .busy(busy), .done(done), .err(err)
    );

    assign dut_state = {x0_o, x1_o, x2_o, x3_o, x4_o};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [319:0] ref_round(input logic [319:0] s, input int i);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v, o;
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        x[2][7:0] = x[2][7:0] ^ 8'(((15 - i) << 4) | i);
        for (int j = 0; j < 64; j++) begin
            v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
            o = SBOX[v];
            for (int k = 0; k < 5; k++) y[k][j] = o[4-k];
        end
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 64; j++)
                x[k][j] = y[k][j] ^ y[k][(j + ROT_A[k]) % 64] ^ y[k][(j + ROT_B[k]) % 64];
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
        logic [319:0] r;
        r = s;
        for (int k = 0; k < n; k++) r = ref_round(r, 12 - n + k);
        return r;
    endfunction

    function automatic int nrounds(input logic [1:0] sel);
        return (sel == 2'd0) ? 6 : (sel == 2'd1) ? 8 : 12;
    endfunction

    // scoreboard
    logic [319:0] exp_q[$];
    int           lat_q[$];
    int           acc_q[$];
    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;
    int last_done = 0;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [319:0] es;
        int el, ea;
        #1;
        if (rst_n) begin
            if (done || err) check("done_err_excl", 320'(done & err), 320'(0));
            if (busy) busy_cnt++;
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_done", 320'(done), 320'(0));
                end else begin
                    es = exp_q.pop_front();
                    el = lat_q.pop_front();
                    ea = acc_q.pop_front();
                    check("result", dut_state, es);
                    check("latency", 320'(cyc - ea), 320'(el));
                end
                last_done = cyc;
            end
        end
    end

    // driver tasks (called at a negedge, return at the negedge after the accept edge)
    task automatic start_perm(input logic [1:0] sel, input logic [319:0] s);
        {x0_i, x1_i, x2_i, x3_i, x4_i} = s;
        rounds_sel = sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        {x0_i, x1_i, x2_i, x3_i, x4_i} = {10{$urandom}};
        rounds_sel = 2'($urandom_range(0, 3));
        exp_q.push_back(ref_perm(s, nrounds(sel)));
        lat_q.push_back(nrounds(sel) / U);
        acc_q.push_back(cyc);
    endtask

    task automatic pulse_start_ignored();
        {x0_i, x1_i, x2_i, x3_i, x4_i} = {10{$urandom}};
        rounds_sel = 2'($urandom_range(0, 2));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("timeout_pending", 320'(exp_q.size()), 320'(0));
    endtask

    function automatic logic [319:0] rand_state();
        return {10{$urandom}} ^ {$urandom, $urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [319:0] s, prev, r1;
        int dc0, ec0, d1;
        rst_n = 1'b0;
        start = 1'b0;
        rounds_sel = 2'd0;
        {x0_i, x1_i, x2_i, x3_i, x4_i} = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {dut_state, busy, done, err}, 323'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Ascon-128 init state, p12
        busy_cnt = 0;
        start_perm(2'd2, {64'h80400c0600000000, 256'h0});
        check("busy_after_start", 320'(busy), 320'(1));
        wait_empty(40);
        check("p12_busy_cycles", 320'(busy_cnt), 320'(12 / U));

        // p8 random state, probe the first round
        s = rand_state();
        start_perm(2'd1, s);
        @(negedge clk);
        r1 = s;
        for (int u = 0; u < U; u++) r1 = ref_round(r1, 4 + u);
        check("p8_first_rounds", dut_state, r1);
        check("p8_x2_const_b4", 320'((dut_state[135:128])), 320'(r1[135:128]));
        wait_empty(40);

        // p6 with starts while busy being ignored
        dc0 = done_cnt;
        s = rand_state();
        start_perm(2'd0, s);
        pulse_start_ignored();
        @(negedge clk);
        pulse_start_ignored();
        wait_empty(40);
        repeat (15) @(negedge clk);
        check("p6_single_done", 320'(done_cnt - dc0), 320'(1));

        // illegal rounds_sel
        prev = dut_state;
        ec0 = err_cnt;
        dc0 = done_cnt;
        rounds_sel = 2'd3;
        {x0_i, x1_i, x2_i, x3_i, x4_i} = rand_state();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 320'(err), 320'(1));
        check("err_busy_low", 320'(busy), 320'(0));
        check("err_state_kept", dut_state, prev);
        @(negedge clk);
        check("err_one_cycle", 320'(err), 320'(0));
        repeat (10) @(negedge clk);
        check("err_count", 320'(err_cnt - ec0), 320'(1));
        check("err_no_done", 320'(done_cnt - dc0), 320'(0));

        // back-to-back: second start in the done cycle
        start_perm(2'd1, rand_state());
        begin
            int k;
            k = 0;
            while (!done && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("b2b_first_done_seen", 320'(done), 320'(1));
        end
        d1 = last_done;
        start_perm(2'd0, rand_state());
        wait_empty(40);
        check("b2b_done_spacing", 320'(last_done - d1), 320'(6 / U + 1));

        // random mix of legal permutations
        for (int t = 0; t < 4; t++) begin
            start_perm(2'($urandom_range(0, 2)), rand_state());
            wait_empty(40);
        end

        // async reset in the middle of a p12 run
        start_perm(2'd2, rand_state());
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_clear", {dut_state, busy, done, err}, 323'(0));
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_perm(2'd1, rand_state());
        wait_empty(40);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
